// File: rtl/pwm_pkg.sv
// pwm_pkg: shared defaults and scheduler state type for the PWM rise/fall edge path.
package pwm_pkg;

  localparam int DEF_WIDTH  = 13;
  localparam int DEF_DEPTH  = 249;
  localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } sched_state_t;

endpackage

// File: rtl/pwm_edge_calc.sv
// pwm_edge_calc: two-stage pipeline turning one channel's duty/phase/cycle into rise/fall edge times.
// Stage 1 clamps the duty to the period, wraps the phase once and splits the duty into two halves.
// Stage 2 places the halves either side of the phase and wraps each edge back into the period.
module pwm_edge_calc
  import pwm_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  duty_i,
  input  logic [WIDTH-1:0]  phase_i,
  input  logic [WIDTH-1:0]  cycle_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [WIDTH-1:0]  rise_o,
  output logic [WIDTH-1:0]  fall_o
);

  logic [WIDTH-1:0]  d_d;
  logic [WIDTH-1:0]  p_d;
  logic [WIDTH-1:0]  hl_d;
  logic [WIDTH-1:0]  hh_d;

  logic              valid1_q;
  logic [ADDR_W-1:0] addr1_q;
  logic [WIDTH-1:0]  p1_q;
  logic [WIDTH-1:0]  hl1_q;
  logic [WIDTH-1:0]  hh1_q;
  logic [WIDTH-1:0]  cyc1_q;

  logic [WIDTH:0]    p_x;
  logic [WIDTH:0]    hl_x;
  logic [WIDTH:0]    hh_x;
  logic [WIDTH:0]    cyc_x;
  logic [WIDTH:0]    sum_x;
  logic [WIDTH-1:0]  rise_d;
  logic [WIDTH-1:0]  fall_d;

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]  rise_q;
  logic [WIDTH-1:0]  fall_q;

  // Stage 1 math: clamp duty, single phase wrap, split duty with the odd LSB going to the high half.
  always_comb begin
    d_d  = (duty_i < cycle_i) ? duty_i : cycle_i;
    p_d  = (phase_i >= cycle_i) ? (phase_i - cycle_i) : phase_i;
    hl_d = d_d >> 1;
    hh_d = d_d - hl_d;
  end

  // Stage 1 register: hold the prepared operands of the channel currently returned by the RAM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid1_q <= 1'b0;
      addr1_q  <= '0;
      p1_q     <= '0;
      hl1_q    <= '0;
      hh1_q    <= '0;
      cyc1_q   <= '0;
    end else begin
      valid1_q <= valid_i;
      if (valid_i) begin
        addr1_q <= addr_i;
        p1_q    <= p_d;
        hl1_q   <= hl_d;
        hh1_q   <= hh_d;
        cyc1_q  <= cycle_i;
      end
    end
  end

  // Stage 2 math: one extra bit of headroom so the sums and wrap tests never overflow.
  always_comb begin
    p_x   = {1'b0, p1_q};
    hl_x  = {1'b0, hl1_q};
    hh_x  = {1'b0, hh1_q};
    cyc_x = {1'b0, cyc1_q};
    sum_x = p_x + hh_x;
    if (cyc1_q == '0) begin
      rise_d = '0;
      fall_d = '0;
    end else begin
      rise_d = (p_x >= hl_x) ? WIDTH'(p_x - hl_x) : WIDTH'(p_x + cyc_x - hl_x);
      fall_d = (sum_x >= cyc_x) ? WIDTH'(sum_x - cyc_x) : WIDTH'(sum_x);
    end
  end

  // Stage 2 register: publish the edge write; edge values and address hold between writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      valid_q <= valid1_q;
      if (valid1_q) begin
        addr_q <= addr1_q;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/pwm_rise_fall_scheduler.sv
// pwm_rise_fall_scheduler: on start, reads every channel's drive settings once (one per cycle)
// and streams the computed rise/fall edges, in channel order, into the edge register bank.
module pwm_rise_fall_scheduler
  import pwm_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [WIDTH-1:0]  duty_i,
  input  logic [WIDTH-1:0]  phase_i,
  input  logic [WIDTH-1:0]  cycle_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [WIDTH-1:0]  rise_o,
  output logic [WIDTH-1:0]  fall_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  sched_state_t      state_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              busy_q;
  logic              done_q;

  logic              rd_vld_q;
  logic [ADDR_W-1:0] rd_vld_addr_q;

  // Pass sequencer: issue reads back to back, wait for the last edge write, then pulse done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q   <= RUN;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        RUN: begin
          if (rd_addr_q == LAST_ADDR) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (wr_en_o && (wr_addr_o == LAST_ADDR)) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Delay the read strobe and address by the RAM latency so they line up with the returned data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_vld_q      <= 1'b0;
      rd_vld_addr_q <= '0;
    end else begin
      rd_vld_q      <= rd_en_q;
      rd_vld_addr_q <= rd_addr_q;
    end
  end

  pwm_edge_calc #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_edge_calc (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (rd_vld_q),
    .addr_i  (rd_vld_addr_q),
    .duty_i  (duty_i),
    .phase_i (phase_i),
    .cycle_i (cycle_i),
    .valid_o (wr_en_o),
    .addr_o  (wr_addr_o),
    .rise_o  (rise_o),
    .fall_o  (fall_o)
  );

  assign rd_en_o   = rd_en_q;
  assign rd_addr_o = rd_addr_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule
